// File: rtl/muldiv4_cmd_seq.sv
// Command sequencer in front of the muldiv4 core: issues operand commands, waits for completion
// and queues results (or locally generated error results) in a first-word-fall-through FIFO.
module muldiv4_cmd_seq #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_op,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] core_a,
    output logic [3:0] core_b,
    output logic       core_op,
    output logic       core_valid,
    input  logic       core_ready,
    input  logic       core_done,
    input  logic [7:0] core_result,
    output logic [7:0] out_data,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [7:0]    TIMER_END = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      timer_q, timer_d;
    logic [3:0]      core_a_q, core_a_d;
    logic [3:0]      core_b_q, core_b_d;
    logic            core_op_q, core_op_d;
    logic            core_valid_q, core_valid_d;
    logic [8:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   remain;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_err_q, out_err_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            accept, pop, push, push_err;
    logic [7:0]      push_data;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        core_op_d    = core_op_q;
        core_valid_d = core_valid_q;
        out_data_d   = out_data_q;
        out_err_d    = out_err_q;
        err_cnt_d    = err_cnt_q;
        push         = 1'b0;
        push_err     = 1'b0;
        push_data    = '0;
        accept       = in_valid & in_ready_q;
        pop          = out_valid_q & out_ready;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_op && (in_data[3:0] == 4'd0)) begin
                        push      = 1'b1;
                        push_err  = 1'b1;
                        push_data = '1;
                    end else begin
                        state_d      = S_ISSUE;
                        core_a_d     = in_data[7:4];
                        core_b_d     = in_data[3:0];
                        core_op_d    = in_op;
                        core_valid_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (core_valid_q && core_ready) begin
                    state_d      = S_WAIT;
                    core_valid_d = 1'b0;
                    timer_d      = '0;
                end
            end
            S_WAIT: begin
                if (core_done) begin
                    state_d   = S_IDLE;
                    push      = 1'b1;
                    push_data = core_result;
                end else if (timer_q == TIMER_END) begin
                    state_d   = S_IDLE;
                    push      = 1'b1;
                    push_err  = 1'b1;
                    push_data = '1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        remain   = count_q - CW'(pop);
        count_d  = remain + CW'(push);

        // Head register: a push into an otherwise-empty queue bypasses the memory.
        if (count_d != '0) begin
            if (remain == '0) begin
                out_data_d = push_data;
                out_err_d  = push_err;
            end else begin
                out_data_d = mem_q[rd_ptr_d][7:0];
                out_err_d  = mem_q[rd_ptr_d][8];
            end
        end

        if (push && push_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        out_valid_d = (count_d != '0);
        in_ready_d  = (state_d == S_IDLE) && (count_d < DEPTH_C);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            core_op_q    <= 1'b0;
            core_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            core_op_q    <= core_op_d;
            core_valid_q <= core_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            err_cnt_q    <= err_cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {push_err, push_data};
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign core_op    = core_op_q;
    assign core_valid = core_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_muldiv4_cmd_seq.sv
// Directed bench for muldiv4_cmd_seq: the core side is driven by hand, expectations are fixed constants.
module tb_muldiv4_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_op;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] core_a;
    logic [3:0] core_b;
    logic       core_op;
    logic       core_valid;
    logic       core_ready;
    logic       core_done;
    logic [7:0] core_result;
    logic [7:0] out_data;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [7:0] err_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    muldiv4_cmd_seq #(.DEPTH(2), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_op(in_op), .in_valid(in_valid), .in_ready(in_ready),
        .core_a(core_a), .core_b(core_b), .core_op(core_op), .core_valid(core_valid),
        .core_ready(core_ready), .core_done(core_done), .core_result(core_result),
        .out_data(out_data), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err_count(err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_op = 1'b0; in_valid = 1'b0;
        core_ready = 1'b0; core_done = 1'b0; core_result = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready",   16'(in_ready),   16'd0);
        chk("rst_core_valid", 16'(core_valid), 16'd0);
        chk("rst_core_a",     16'(core_a),     16'd0);
        chk("rst_out_valid",  16'(out_valid),  16'd0);
        chk("rst_out_data",   16'(out_data),   16'd0);
        chk("rst_out_err",    16'(out_err),    16'd0);
        chk("rst_busy",       16'(busy),       16'd0);
        chk("rst_err_count",  16'(err_count),  16'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 16'(in_ready), 16'd1);

        // multiply 7*13, core stalls ready for one cycle
        in_data = 8'h7D; in_op = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mul_core_valid", 16'(core_valid), 16'd1);
        chk("mul_core_a",     16'(core_a),     16'h7);
        chk("mul_core_b",     16'(core_b),     16'hD);
        chk("mul_core_op",    16'(core_op),    16'd0);
        chk("mul_busy",       16'(busy),       16'd1);
        chk("mul_in_ready",   16'(in_ready),   16'd0);
        tick();
        chk("mul_hold_valid", 16'(core_valid), 16'd1);
        chk("mul_hold_a",     16'(core_a),     16'h7);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        chk("mul_valid_drop", 16'(core_valid), 16'd0);
        tick(); tick();
        chk("mul_no_out_yet", 16'(out_valid), 16'd0);
        core_done = 1'b1; core_result = 8'h5B;
        tick();
        core_done = 1'b0;
        chk("mul_out_valid", 16'(out_valid), 16'd1);
        chk("mul_out_data",  16'(out_data),  16'h5B);
        chk("mul_out_err",   16'(out_err),   16'd0);
        chk("mul_busy_end",  16'(busy),      16'd0);
        chk("mul_in_ready1", 16'(in_ready),  16'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("mul_popped", 16'(out_valid), 16'd0);

        // core_done in IDLE is ignored
        core_done = 1'b1; core_result = 8'h77;
        tick();
        core_done = 1'b0;
        chk("idle_done_ignored", 16'(out_valid), 16'd0);

        // divide by zero handled locally
        in_data = 8'h90; in_op = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("div0_core_valid", 16'(core_valid), 16'd0);
        chk("div0_out_valid",  16'(out_valid),  16'd1);
        chk("div0_out_data",   16'(out_data),   16'hFF);
        chk("div0_out_err",    16'(out_err),    16'd1);
        chk("div0_err_count",  16'(err_count),  16'd1);
        chk("div0_busy",       16'(busy),       16'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("div0_popped", 16'(out_valid), 16'd0);

        // backpressure: fill both entries with out_ready low
        in_data = 8'h50; in_op = 1'b1; in_valid = 1'b1;
        tick();
        chk("bp_in_ready_cnt1", 16'(in_ready), 16'd1);
        in_data = 8'h73; in_op = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_core_op", 16'(core_op), 16'd1);
        chk("bp_core_b",  16'(core_b),  16'h3);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        core_done = 1'b1; core_result = 8'h21;
        tick();
        core_done = 1'b0;
        chk("bp_full_in_ready", 16'(in_ready), 16'd0);
        chk("bp_head_data",     16'(out_data), 16'hFF);
        chk("bp_head_err",      16'(out_err),  16'd1);
        chk("bp_err_count",     16'(err_count), 16'd2);
        in_data = 8'h40; in_op = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_refused_cnt", 16'(err_count), 16'd2);
        chk("bp_refused_rdy", 16'(in_ready),  16'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_pop_in_ready", 16'(in_ready), 16'd1);
        chk("bp_second_data",  16'(out_data), 16'h21);
        chk("bp_second_err",   16'(out_err),  16'd0);
        // simultaneous push and pop keeps one entry
        in_data = 8'h30; in_op = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pp_out_valid", 16'(out_valid), 16'd1);
        chk("pp_out_data",  16'(out_data),  16'hFF);
        chk("pp_out_err",   16'(out_err),   16'd1);
        chk("pp_err_count", 16'(err_count), 16'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pp_drained", 16'(out_valid), 16'd0);

        // timeout after 15 WAIT cycles
        in_data = 8'h23; in_op = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("to_not_yet_valid", 16'(out_valid), 16'd0);
        chk("to_not_yet_busy",  16'(busy),      16'd1);
        tick();
        chk("to_out_valid", 16'(out_valid), 16'd1);
        chk("to_out_data",  16'(out_data),  16'hFF);
        chk("to_out_err",   16'(out_err),   16'd1);
        chk("to_busy",      16'(busy),      16'd0);
        chk("to_err_count", 16'(err_count), 16'd4);

        // reset mid-WAIT discards everything, later core_done ignored
        in_data = 8'h11; in_op = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        core_done = 1'b1; core_result = 8'h01;
        tick();
        core_done = 1'b0;
        chk("rw_out_valid", 16'(out_valid), 16'd0);
        chk("rw_busy",      16'(busy),      16'd0);
        chk("rw_err_count", 16'(err_count), 16'd0);
        chk("rw_in_ready",  16'(in_ready),  16'd1);

        // err_count saturation with 260 back-to-back div-by-zero commands
        in_data = 8'h90; in_op = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 254; i++) tick();
        chk("sat_254", 16'(err_count), 16'hFE);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_260", 16'(err_count), 16'hFF);
        in_valid = 1'b0;
        tick();
        chk("sat_drained", 16'(out_valid), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
